// File: rtl/hnf_pkg.sv
// hnf_pkg: CHI flit layouts, opcodes and snoop-filter state encodings shared by the HN-F snoop path.
package hnf_pkg;
  localparam int TXNID_W = 8;
  localparam int NODEID_W = 7;
  localparam int OPCODE_W = 7;
  localparam int ADDR_W = 48;
  localparam int CHI_CACHE_STATE_W = 2;
  localparam logic [OPCODE_W-1:0] OP_ReadShared = 7'h01;
  localparam logic [OPCODE_W-1:0] OP_ReadUnique = 7'h07;
  localparam logic [OPCODE_W-1:0] OP_WriteBackFull = 7'h1B;
  localparam logic [OPCODE_W-1:0] OP_SnpShared = 7'h01;
  localparam logic [OPCODE_W-1:0] OP_SnpUnique = 7'h07;
  localparam logic [OPCODE_W-1:0] OP_SnpResp = 7'h01;
  localparam logic [OPCODE_W-1:0] OP_SnpRespData = 7'h02;
  localparam logic [CHI_CACHE_STATE_W-1:0] SF_I = 2'd0;
  localparam logic [CHI_CACHE_STATE_W-1:0] SF_SC = 2'd1;
  localparam logic [CHI_CACHE_STATE_W-1:0] SF_UC = 2'd2;
  localparam logic [CHI_CACHE_STATE_W-1:0] SF_UD = 2'd3;
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0] addr;
    logic [NODEID_W-1:0] srcid;
    logic [TXNID_W-1:0] txnid;
  } reqflit_t;
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-4:0] addr;
    logic [NODEID_W-1:0] srcid;
    logic [NODEID_W-1:0] tgtid;
    logic [NODEID_W-1:0] fwdnid;
    logic [TXNID_W-1:0] txnid;
  } snpflit_t;
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [2:0] resp;
    logic [NODEID_W-1:0] srcid;
    logic [NODEID_W-1:0] tgtid;
    logic [TXNID_W-1:0] txnid;
  } rspflit_t;
  function automatic logic is_supported(input logic [OPCODE_W-1:0] op);
    return op == OP_ReadUnique || op == OP_ReadShared;
  endfunction
endpackage

// File: rtl/hnf_snp_ctl_if.sv
// hnf_snp_ctl_if: POCQ request, SF lookup, TXSNP/RXRSP and completion signals around the snoop issuer.
interface hnf_snp_ctl_if #(parameter int RNF_W = 3);
  import hnf_pkg::*;
  reqflit_t req_in;
  logic req_in_valid;
  logic req_in_ready;
  logic sf_hit;
  logic [CHI_CACHE_STATE_W-1:0] sf_hit_state;
  logic [RNF_W-1:0] sf_owner;
  snpflit_t snp_out;
  logic snp_out_valid;
  logic snp_out_ready;
  rspflit_t snp_rsp;
  logic snp_rsp_valid;
  logic done_valid;
  logic [TXNID_W-1:0] done_txnid;
  logic done_need_mem;
  logic done_dirty;
  logic done_err;
  logic sf_upd_valid;
  logic [CHI_CACHE_STATE_W-1:0] sf_upd_state;
  logic [RNF_W-1:0] sf_upd_id;
  modport slave (
    input req_in, req_in_valid, sf_hit, sf_hit_state, sf_owner, snp_out_ready, snp_rsp, snp_rsp_valid,
    output req_in_ready, snp_out, snp_out_valid, done_valid, done_txnid, done_need_mem, done_dirty,
      done_err, sf_upd_valid, sf_upd_state, sf_upd_id
  );
  modport master (
    output req_in, req_in_valid, sf_hit, sf_hit_state, sf_owner, snp_out_ready, snp_rsp, snp_rsp_valid,
    input req_in_ready, snp_out, snp_out_valid, done_valid, done_txnid, done_need_mem, done_dirty,
      done_err, sf_upd_valid, sf_upd_state, sf_upd_id
  );
endinterface

// File: rtl/hnf_snp_timeout.sv
// hnf_snp_timeout: saturating 16-bit wait counter; expired marks the last permitted wait cycle.
module hnf_snp_timeout #(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + 16'd1 : cnt_q;
  // the wait therefore spans exactly LIMIT cycles
  assign expired = en && cnt_q >= 16'(LIMIT - 1);
  always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/hnf_snp_ctl.sv
// hnf_snp_ctl: HN-F snoop issuer; turns a POCQ request plus SF lookup into one CHI snoop and a completion.
module hnf_snp_ctl
  import hnf_pkg::*;
#(
  parameter logic [NODEID_W-1:0] HNF_ID = '0,
  parameter int RNF_W = 3,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input logic clock,
  input logic reset,
  hnf_snp_ctl_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_SNP = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;
  logic [1:0] state_q, state_d;
  reqflit_t req_q, req_d;
  logic [RNF_W-1:0] owner_q, owner_d, req_id;
  logic hit_q, hit_d, unsup_q, unsup_d, err_q, err_d, need_q, need_d, dirty_q, dirty_d;
  logic in_hit, in_unsup, match, expired, in_snp, in_done, upd;
  assign in_hit = bus.sf_hit && bus.sf_hit_state != SF_I;
  assign in_unsup = !is_supported(bus.req_in.opcode);
  assign req_id = req_q.srcid[RNF_W-1:0];
  assign match = state_q == S_WAIT && bus.snp_rsp_valid && bus.snp_rsp.txnid == req_q.txnid &&
                 (bus.snp_rsp.opcode == OP_SnpResp || bus.snp_rsp.opcode == OP_SnpRespData) &&
                 bus.snp_rsp.srcid == NODEID_W'(owner_q);
  hnf_snp_timeout #(.LIMIT(TIMEOUT_CYC)) u_tmo (
    .clock(clock),
    .reset(reset),
    .clr(state_q == S_SNP),
    .en(state_q == S_WAIT && !match),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    owner_d = owner_q;
    hit_d = hit_q;
    unsup_d = unsup_q;
    err_d = err_q;
    need_d = need_q;
    dirty_d = dirty_q;
    case (state_q)
      S_IDLE: if (bus.req_in_valid) begin
        req_d = bus.req_in;
        owner_d = bus.sf_owner;
        hit_d = in_hit;
        unsup_d = in_unsup;
        err_d = in_unsup;
        need_d = !in_unsup;
        dirty_d = 1'b0;
        state_d = (in_unsup || !in_hit || bus.sf_owner == bus.req_in.srcid[RNF_W-1:0]) ? S_DONE : S_SNP;
      end
      S_SNP: state_d = bus.snp_out_ready ? S_WAIT : S_SNP;
      S_WAIT: if (match) begin
        state_d = S_DONE;
        dirty_d = bus.snp_rsp.resp[2];
        need_d = bus.snp_rsp.opcode == OP_SnpResp;
      end else if (expired) begin
        state_d = S_DONE;
        err_d = 1'b1;
        need_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) state_q <= reset ? S_IDLE : state_d;
  always_ff @(posedge clock) begin
    req_q <= req_d;
    owner_q <= owner_d;
    hit_q <= hit_d;
    unsup_q <= unsup_d;
    err_q <= err_d;
    need_q <= need_d;
    dirty_q <= dirty_d;
  end
  // every output is forced low while reset is held, even mid-transaction
  assign in_snp = state_q == S_SNP && !reset;
  assign in_done = state_q == S_DONE && !reset;
  assign upd = in_done && !unsup_q;
  assign bus.req_in_ready = state_q == S_IDLE && !reset;
  assign bus.snp_out_valid = in_snp;
  assign bus.snp_out = in_snp ? snpflit_t'{
    opcode: req_q.opcode == OP_ReadUnique ? OP_SnpUnique : OP_SnpShared,
    addr: req_q.addr[ADDR_W-1:3],
    srcid: HNF_ID,
    tgtid: NODEID_W'(owner_q),
    fwdnid: req_q.srcid,
    txnid: req_q.txnid
  } : '0;
  assign bus.done_valid = in_done;
  assign bus.done_txnid = in_done ? req_q.txnid : '0;
  assign bus.done_need_mem = in_done && need_q;
  assign bus.done_dirty = in_done && dirty_q;
  assign bus.done_err = in_done && err_q;
  assign bus.sf_upd_valid = upd;
  assign bus.sf_upd_state = !upd ? SF_I : req_q.opcode == OP_ReadUnique ? (dirty_q ? SF_UD : SF_UC) : SF_SC;
  assign bus.sf_upd_id = !upd ? '0 : (req_q.opcode == OP_ReadShared && hit_q) ? owner_q : req_id;
endmodule

// File: tb/tb_hnf_snp_ctl.sv
// tb_hnf_snp_ctl: random and directed transactions against a per-cycle expectation timeline.
module tb_hnf_snp_ctl;
  import hnf_pkg::*;
  localparam int RNF_W = 3;
  localparam int TMO = 8;
  localparam int MAXC = 20000;
  localparam logic [NODEID_W-1:0] HNF = 7'd5;
  typedef struct packed {
    logic rst;
    logic ready;
    logic snp_v;
    snpflit_t snp;
    logic done;
    logic [TXNID_W-1:0] txnid;
    logic need;
    logic dirty;
    logic err;
    logic upd_v;
    logic [CHI_CACHE_STATE_W-1:0] upd_st;
    logic [RNF_W-1:0] upd_id;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t ex [MAXC];
  exp_t idle_e, rst_e;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  hnf_snp_ctl_if #(.RNF_W(RNF_W)) bus ();
  hnf_snp_ctl #(.HNF_ID(HNF), .RNF_W(RNF_W), .TIMEOUT_CYC(TMO)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, a, r);
    end
  endtask
  always @(negedge clock) begin
    if (cyc > 0 && cyc < MAXC) begin
      if (ex[cyc].rst)
        chk("reset_outputs", {bus.req_in_ready, bus.snp_out_valid, bus.snp_out, bus.done_valid, bus.done_txnid,
            bus.done_need_mem, bus.done_dirty, bus.done_err, bus.sf_upd_valid, bus.sf_upd_state, bus.sf_upd_id}, '0);
      else begin
        chk("req_in_ready", bus.req_in_ready, ex[cyc].ready);
        chk("snp_out_valid", bus.snp_out_valid, ex[cyc].snp_v);
        if (ex[cyc].snp_v) chk("snp_out", bus.snp_out, ex[cyc].snp);
        chk("done_valid", bus.done_valid, ex[cyc].done);
        if (ex[cyc].done)
          chk("done_fields", {bus.done_txnid, bus.done_need_mem, bus.done_dirty, bus.done_err},
              {ex[cyc].txnid, ex[cyc].need, ex[cyc].dirty, ex[cyc].err});
        chk("sf_upd_valid", bus.sf_upd_valid, ex[cyc].upd_v);
        if (ex[cyc].upd_v) chk("sf_upd", {bus.sf_upd_state, bus.sf_upd_id}, {ex[cyc].upd_st, ex[cyc].upd_id});
      end
    end
  end
  task automatic idle_inputs();
    bus.req_in = '0;
    bus.req_in_valid = 1'b0;
    bus.sf_hit = 1'b0;
    bus.sf_hit_state = SF_I;
    bus.sf_owner = '0;
    bus.snp_out_ready = 1'b0;
    bus.snp_rsp = '0;
    bus.snp_rsp_valid = 1'b0;
  endtask
  function automatic rspflit_t junk_flit(input rspflit_t g);
    rspflit_t j;
    j = g;
    case ($urandom_range(0, 2))
      0: j.txnid = g.txnid ^ 8'($urandom_range(1, 255));
      1: j.srcid = g.srcid ^ 7'($urandom_range(1, 127));
      default: j.opcode = 7'($urandom_range(3, 127));
    endcase
    return j;
  endfunction
  // Plans the whole transaction on the timeline from the rules, then drives it cycle by cycle.
  task automatic run_txn(input reqflit_t r, input logic hit, input logic [1:0] st, input logic [RNF_W-1:0] own,
                         input int rdy_low, input logic tmo, input int m_off, input logic data,
                         input logic [2:0] resp, input logic junk, input int rst_off, output int cd);
    int c0, h, m;
    logic sup, snoop, dirty;
    exp_t e, d;
    snpflit_t sf;
    rspflit_t mr;
    c0 = cyc;
    sup = r.opcode == OP_ReadUnique || r.opcode == OP_ReadShared;
    snoop = sup && hit && own != r.srcid[RNF_W-1:0];
    h = c0 + 1 + rdy_low;
    m = h + m_off;
    cd = !snoop ? c0 + 1 : tmo ? h + TMO + 1 : m + 1;
    dirty = snoop && !tmo && resp[2];
    d = '0;
    d.done = 1'b1;
    d.txnid = r.txnid;
    d.err = !sup || (snoop && tmo);
    d.need = sup && !(snoop && !tmo && data);
    d.dirty = dirty;
    d.upd_v = sup;
    d.upd_st = r.opcode == OP_ReadUnique ? (dirty ? SF_UD : SF_UC) : SF_SC;
    d.upd_id = (r.opcode == OP_ReadShared && hit) ? own : r.srcid[RNF_W-1:0];
    sf = '{opcode: r.opcode == OP_ReadUnique ? OP_SnpUnique : OP_SnpShared, addr: r.addr[47:3], srcid: HNF,
           tgtid: 7'(own), fwdnid: r.srcid, txnid: r.txnid};
    mr = '{opcode: data ? OP_SnpRespData : OP_SnpResp, resp: resp, srcid: 7'(own), tgtid: HNF, txnid: r.txnid};
    for (int c = c0 + 1; c < cd; c++) begin
      e = '0;
      e.snp_v = snoop && c <= h;
      e.snp = sf;
      ex[c] = e;
    end
    ex[cd] = d;
    if (rst_off > 0 && c0 + rst_off <= cd) begin
      for (int c = c0 + rst_off + 1; c <= cd; c++) ex[c] = idle_e;
      ex[c0 + rst_off] = rst_e;
      cd = c0 + rst_off;
    end
    for (int c = c0; c <= cd; c++) begin
      bus.req_in = r;
      bus.req_in_valid = c == c0 || $urandom_range(0, 3) == 0;
      bus.sf_hit = hit;
      bus.sf_hit_state = st;
      bus.sf_owner = own;
      bus.snp_out_ready = !snoop ? 1'($urandom) : c < h ? 1'b0 : c == h ? 1'b1 : 1'($urandom);
      bus.snp_rsp_valid = 1'b0;
      bus.snp_rsp = '0;
      if (snoop && !tmo && c == m) begin
        bus.snp_rsp_valid = 1'b1;
        bus.snp_rsp = mr;
      end else if (junk && $urandom_range(0, 1) == 1) begin
        bus.snp_rsp_valid = 1'b1;
        bus.snp_rsp = junk_flit(mr);
      end
      reset = rst_off > 0 && c == c0 + rst_off;
      @(posedge clock);
      #1;
    end
    idle_inputs();
    reset = 1'b0;
  endtask
  initial begin
    int cd, c0, rst_off;
    reqflit_t r;
    logic hit;
    logic [1:0] st;
    logic [RNF_W-1:0] own;
    idle_e = '0;
    idle_e.ready = 1'b1;
    rst_e = '0;
    rst_e.rst = 1'b1;
    for (int i = 0; i < MAXC; i++) ex[i] = idle_e;
    ex[1] = rst_e;
    ex[2] = rst_e;
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    r = '{opcode: OP_ReadUnique, addr: 48'h1000, srcid: 7'd2, txnid: 8'd5};
    c0 = cyc;
    run_txn(r, 1'b0, SF_I, 3'd0, 0, 1'b0, 1, 1'b0, 3'b000, 1'b0, 0, cd);
    chk("pin_miss_cycle", 32'(cd), 32'(c0 + 1));
    chk("pin_miss", {ex[cd].txnid, ex[cd].need, ex[cd].err, ex[cd].upd_st, ex[cd].upd_id}, {8'd5, 1'b1, 1'b0, SF_UC, 3'd2});
    c0 = cyc;
    run_txn(r, 1'b1, SF_UD, 3'd1, 0, 1'b0, 1, 1'b1, 3'b110, 1'b0, 0, cd);
    chk("pin_hit_snp", {ex[c0 + 1].snp.opcode, ex[c0 + 1].snp.addr, ex[c0 + 1].snp.tgtid, ex[c0 + 1].snp.fwdnid},
        {OP_SnpUnique, 45'h200, 7'd1, 7'd2});
    chk("pin_hit_cycle", 32'(cd), 32'(c0 + 3));
    chk("pin_hit_done", {ex[cd].need, ex[cd].dirty, ex[cd].upd_st, ex[cd].upd_id}, {1'b0, 1'b1, SF_UD, 3'd2});
    c0 = cyc;
    run_txn(r, 1'b1, SF_UC, 3'd1, 4, 1'b0, 3, 1'b0, 3'b000, 1'b1, 0, cd);
    chk("pin_bp_done", {ex[cd].need, ex[cd].dirty, ex[cd].err}, {1'b1, 1'b0, 1'b0});
    c0 = cyc;
    run_txn(r, 1'b1, SF_UC, 3'd1, 0, 1'b1, 1, 1'b0, 3'b000, 1'b0, 0, cd);
    chk("pin_tmo_cycle", 32'(cd), 32'(c0 + 1 + 9));
    chk("pin_tmo_done", {ex[cd].need, ex[cd].err}, {1'b1, 1'b1});
    c0 = cyc;
    run_txn(r, 1'b1, SF_UC, 3'd1, 0, 1'b0, TMO, 1'b1, 3'b000, 1'b0, 0, cd);
    chk("pin_tmo_race", {32'(cd), ex[cd].err, ex[cd].need}, {32'(c0 + 1 + 9), 1'b0, 1'b0});
    r = '{opcode: OP_ReadShared, addr: 48'h2040, srcid: 7'd2, txnid: 8'd9};
    c0 = cyc;
    run_txn(r, 1'b1, SF_SC, 3'd2, 0, 1'b0, 1, 1'b0, 3'b000, 1'b1, 0, cd);
    chk("pin_self_owner", {32'(cd), ex[cd].need, ex[cd].upd_st, ex[cd].upd_id}, {32'(c0 + 1), 1'b1, SF_SC, 3'd2});
    r = '{opcode: OP_WriteBackFull, addr: 48'h3000, srcid: 7'd3, txnid: 8'd7};
    run_txn(r, 1'b1, SF_UD, 3'd1, 0, 1'b0, 1, 1'b0, 3'b000, 1'b0, 0, cd);
    chk("pin_unsup", {ex[cd].err, ex[cd].need, ex[cd].upd_v}, {1'b1, 1'b0, 1'b0});
    r = '{opcode: OP_ReadUnique, addr: 48'h4000, srcid: 7'd4, txnid: 8'd3};
    c0 = cyc;
    run_txn(r, 1'b1, SF_UC, 3'd6, 0, 1'b1, 1, 1'b0, 3'b000, 1'b1, 4, cd);
    chk("pin_reset_abort", {ex[c0 + 4].rst, ex[c0 + 5].done}, {1'b1, 1'b0});
    run_txn(r, 1'b0, SF_I, 3'd0, 0, 1'b0, 1, 1'b0, 3'b000, 1'b0, 0, cd);
    for (int t = 0; t < 250; t++) begin
      r.opcode = $urandom_range(0, 4) == 0 ? ($urandom_range(0, 1) == 1 ? OP_WriteBackFull : 7'h02)
                                           : ($urandom_range(0, 1) == 1 ? OP_ReadUnique : OP_ReadShared);
      r.addr = {16'($urandom), 32'($urandom)};
      r.srcid = 7'($urandom);
      r.txnid = 8'($urandom);
      own = $urandom_range(0, 2) == 0 ? r.srcid[RNF_W-1:0] : 3'($urandom);
      hit = 1'($urandom);
      st = hit ? 2'($urandom_range(1, 3)) : 2'($urandom);
      rst_off = $urandom_range(0, 19) == 0 ? $urandom_range(1, 6) : 0;
      run_txn(r, hit, st, own, $urandom_range(0, 3), $urandom_range(0, 4) == 0, $urandom_range(1, TMO),
              1'($urandom), 3'($urandom), 1'b1, rst_off, cd);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
    end
    repeat (3) @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
